// File: rtl/cache_fill_if.sv
// cache_fill_if: miss request, memory request/return and cache write signals of cache_fill_fsm
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] fill_word_address;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] block_base;
  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_read_en, memory_address, write_data_array,
           fill_word_address, fill_data, write_tag_array, block_base
  );
  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_read_en, memory_address, write_data_array,
           fill_word_address, fill_data, write_tag_array, block_base
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches the 8-word block of a missed address from pipelined memory into the cache
module cache_fill_fsm #(
  parameter int MEM_LATENCY = 4
) (
  input logic         clk,
  input logic         rst_n,
  cache_fill_if.slave bus
);
  if (MEM_LATENCY < 1) begin : g_lat
    $error("MEM_LATENCY must be at least 1");
  end
  typedef enum logic {IDLE, FILL} state_t;
  state_t      state;
  logic [3:0]  req_cnt;
  logic [2:0]  rcv_cnt;
  logic [15:0] base;
  logic        fill;
  logic        wr;
  assign fill = state == FILL;
  assign wr   = fill && bus.memory_data_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      req_cnt <= '0;
      rcv_cnt <= '0;
      base    <= '0;
    end else if (!fill) begin
      if (bus.miss_detected) begin
        state   <= FILL;
        base    <= bus.miss_address & 16'hFFF0;
        req_cnt <= '0;
        rcv_cnt <= '0;
      end
    end else begin
      if (!req_cnt[3]) req_cnt <= req_cnt + 4'd1;
      if (wr) rcv_cnt <= rcv_cnt + 3'd1;
      if (wr && rcv_cnt == 3'd7) state <= IDLE;
    end
  // base has its low nibble cleared, so OR-ing the word offset never carries
  assign bus.fsm_busy          = fill;
  assign bus.memory_read_en    = fill && !req_cnt[3];
  assign bus.memory_address    = bus.memory_read_en ? base | {12'd0, req_cnt[2:0], 1'b0} : '0;
  assign bus.write_data_array  = wr;
  assign bus.fill_word_address = wr ? base | {12'd0, rcv_cnt, 1'b0} : '0;
  assign bus.fill_data         = bus.memory_data;
  assign bus.write_tag_array   = wr && rcv_cnt == 3'd7;
  assign bus.block_base        = base;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed and random fills against a block-level reference model
module tb_cache_fill_fsm;
  localparam int MEM_LATENCY = 4;
  logic clk = 0;
  logic rst_n = 1;
  cache_fill_if bus();
  cache_fill_fsm #(.MEM_LATENCY(MEM_LATENCY)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic        m_busy = 0;
  logic [15:0] m_base = 0;
  int          m_req = 0, m_rcv = 0;
  logic        e_rd, e_wr, e_tag, e_busy;
  logic [15:0] e_addr, e_wa, e_base;
  int          q_due[$];
  logic [15:0] q_addr[$];
  int          hold = 0, gap_word = -1, gap_len = 0;
  bit          spurious_en = 0, rand_gap = 0;
  logic [15:0] req_log[$], wa_log[$], wd_log[$];
  int          busy_cnt = 0, tag_cnt = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 | {13'd0, a[3:1]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory: fixed latency pipeline, optional withheld cycles and idle-time noise
  initial begin
    logic [15:0] a;
    bus.memory_data_valid = 0;
    bus.memory_data = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.memory_data_valid = 0;
      bus.memory_data = 16'($urandom);
      if (hold > 0) hold--;
      else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        a = q_addr.pop_front();
        void'(q_due.pop_front());
        bus.memory_data_valid = 1;
        bus.memory_data = mem_word(a);
        if (gap_word >= 0 && int'(a[3:1]) == gap_word) hold = gap_len;
        else if (rand_gap && $urandom_range(0, 4) == 0) hold = $urandom_range(1, 3);
      end else if (spurious_en && !m_busy && q_due.size() == 0 && $urandom_range(0, 2) == 0)
        bus.memory_data_valid = 1;
    end
  end

  // compare against the block-fill model, then advance it
  initial forever begin
    @(negedge clk);
    e_busy = rst_n && m_busy;
    e_rd   = e_busy && m_req < 8;
    e_addr = e_rd ? m_base + 16'(2 * m_req) : 16'h0;
    e_wr   = e_busy && bus.memory_data_valid;
    e_wa   = e_wr ? m_base + 16'(2 * m_rcv) : 16'h0;
    e_tag  = e_wr && m_rcv == 7;
    e_base = rst_n ? m_base : 16'h0;
    check("fsm_busy", 16'(bus.fsm_busy), 16'(e_busy));
    check("memory_read_en", 16'(bus.memory_read_en), 16'(e_rd));
    check("memory_address", bus.memory_address, e_addr);
    check("write_data_array", 16'(bus.write_data_array), 16'(e_wr));
    check("fill_word_address", bus.fill_word_address, e_wa);
    check("write_tag_array", 16'(bus.write_tag_array), 16'(e_tag));
    check("block_base", bus.block_base, e_base);
    if (e_wr) check("fill_data", bus.fill_data, mem_word(e_wa));
    if (bus.fsm_busy) busy_cnt++;
    if (bus.memory_read_en) begin
      req_log.push_back(bus.memory_address);
      q_due.push_back(cyc + MEM_LATENCY);
      q_addr.push_back(bus.memory_address);
    end
    if (bus.write_data_array) begin
      wa_log.push_back(bus.fill_word_address);
      wd_log.push_back(bus.fill_data);
    end
    if (bus.write_tag_array) tag_cnt++;
    if (!rst_n) begin
      m_busy = 0; m_base = 0; m_req = 0; m_rcv = 0;
    end else if (!m_busy) begin
      if (bus.miss_detected) begin
        m_busy = 1; m_base = bus.miss_address & 16'hFFF0; m_req = 0; m_rcv = 0;
      end
    end else begin
      if (m_req < 8) m_req++;
      if (bus.memory_data_valid) begin
        m_rcv++;
        if (m_rcv == 8) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete(); wa_log.delete(); wd_log.delete();
    busy_cnt = 0; tag_cnt = 0;
  endtask

  task automatic miss(input logic [15:0] a);
    bus.miss_detected = 1;
    bus.miss_address = a;
    tick();
    bus.miss_detected = 0;
    bus.miss_address = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.fsm_busy && n < 100) begin tick(); n++; end
    check("wait_idle_timeout", 16'(bus.fsm_busy), 16'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (q_due.size() > 0 && n < 60) begin tick(); n++; end
    check("drain_timeout", 16'(q_due.size()), 16'h0);
    tick();
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    #1;
    check("rst_async_busy", 16'(bus.fsm_busy), 16'h0);
    check("rst_async_read_en", 16'(bus.memory_read_en), 16'h0);
    check("rst_async_write", 16'(bus.write_data_array), 16'h0);
    check("rst_async_tag", 16'(bus.write_tag_array), 16'h0);
    check("rst_async_base", bus.block_base, 16'h0);
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic check_block(input string name, input logic [15:0] base, input int busy);
    check({name, "_busy_cycles"}, 16'(busy_cnt), 16'(busy));
    check({name, "_req_count"}, 16'(req_log.size()), 16'd8);
    check({name, "_write_count"}, 16'(wa_log.size()), 16'd8);
    check({name, "_tag_count"}, 16'(tag_cnt), 16'd1);
    for (int i = 0; i < 8; i++) begin
      check({name, "_req_addr"}, req_log[i], base + 16'(2 * i));
      check({name, "_write_addr"}, wa_log[i], base + 16'(2 * i));
      check({name, "_write_data"}, wd_log[i], 16'hA000 + 16'(i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.miss_detected = 0;
    bus.miss_address = 0;
    #2;
    reset_pulse();
    clear_logs();
    spurious_en = 1;
    repeat (12) tick();
    spurious_en = 0;
    check("idle_block_base", bus.block_base, 16'h0);
    check("idle_writes", 16'(wa_log.size()), 16'h0);
    check("idle_busy", 16'(busy_cnt), 16'h0);

    clear_logs();
    miss(16'h1236);
    check("single_base", bus.block_base, 16'h1230);
    wait_idle();
    check_block("single", 16'h1230, 12);

    clear_logs();
    gap_word = 3; gap_len = 3;
    miss(16'h1236);
    wait_idle();
    gap_word = -1;
    check_block("gapped", 16'h1230, 15);

    clear_logs();
    miss(16'h1236);
    repeat (3) tick();
    bus.miss_detected = 1; bus.miss_address = 16'h4000;
    repeat (2) tick();
    bus.miss_detected = 0;
    check("ignored_miss_base", bus.block_base, 16'h1230);
    wait_idle();
    check_block("pre_b2b", 16'h1230, 12);
    clear_logs();
    miss(16'h4000);
    check("b2b_base", bus.block_base, 16'h4000);
    wait_idle();
    check_block("b2b", 16'h4000, 12);

    clear_logs();
    miss(16'h1236);
    for (int n = 0; n < 40 && wa_log.size() < 3; n++) tick();
    check("midfill_words_before_reset", 16'(wa_log.size()), 16'd3);
    reset_pulse();
    clear_logs();
    drain();
    check("stale_writes", 16'(wa_log.size()), 16'h0);
    check("stale_tags", 16'(tag_cnt), 16'h0);
    clear_logs();
    miss(16'h00F2);
    wait_idle();
    check_block("after_reset", 16'h00F0, 12);

    clear_logs();
    miss(16'hFFFE);
    check("blockend_base", bus.block_base, 16'hFFF0);
    wait_idle();
    check_block("blockend", 16'hFFF0, 12);

    spurious_en = 1; rand_gap = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 8)) tick();
        reset_pulse();
        drain();
      end else begin
        repeat ($urandom_range(0, 3)) tick();
        bus.miss_detected = 1;
        bus.miss_address = 16'($urandom);
        repeat ($urandom_range(1, 3)) tick();
        bus.miss_detected = 0;
        repeat ($urandom_range(0, 20)) tick();
      end
    end
    spurious_en = 0; rand_gap = 0;
    wait_idle();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
